axil_wb_master: RTL and testbench

- AXI4-Lite slave to Wishbone classic master bridge. It is the reverse direction of the existing Wishbone-to-AXI path.
- Lets an AXI-Lite initiator (testbench BFM, DMA, or future AXI-side controller) reach Wishbone-mapped user-project registers at base 0x3000_0000.
- Handles one outstanding transaction at a time.
- A bus timeout converts a missing Wishbone ack into an AXI SLVERR response.

---
 rtl/axil_wb_master.sv | 219 +++++++++++++++++++++
 tb/tb_axil_wb_master.sv | 546 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_wb_master.sv
// rtl/axil_wb_master.sv - AXI4-Lite slave to Wishbone classic master bridge
// One transaction in flight; a Wishbone ack that never arrives becomes SLVERR after TIMEOUT cycles.
module axil_wb_master #(
    parameter int          pADDR_WIDTH = 12,
    parameter int          pDATA_WIDTH = 32,
    parameter logic [31:0] WB_BASE     = 32'h3000_0000,
    parameter int          TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic [3:0]             wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [1:0]             rresp,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [3:0]             wbm_sel_o,
    output logic [31:0]            wbm_adr_o,
    output logic [pDATA_WIDTH-1:0] wbm_dat_o,
    input  logic [pDATA_WIDTH-1:0] wbm_dat_i,
    input  logic                   wbm_ack_i,
    output logic                   busy
);

    typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [9:0] CNT_LAST    = 10'(TIMEOUT - 1);

    state_t                 r_state, w_state_nxt;
    logic                   r_aw_got, w_aw_got_nxt;
    logic                   r_w_got, w_w_got_nxt;
    logic [pADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [pDATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [3:0]             r_wstrb, w_wstrb_nxt;
    logic [9:0]             r_cnt, w_cnt_nxt;
    logic                   r_cyc, w_cyc_nxt;
    logic                   r_we, w_we_nxt;
    logic [3:0]             r_sel, w_sel_nxt;
    logic [31:0]            r_adr, w_adr_nxt;
    logic [pDATA_WIDTH-1:0] r_dat, w_dat_nxt;
    logic                   r_bvalid, w_bvalid_nxt;
    logic [1:0]             r_bresp, w_bresp_nxt;
    logic                   r_rvalid, w_rvalid_nxt;
    logic [1:0]             r_rresp, w_rresp_nxt;
    logic [pDATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

    logic w_idle, w_aw_hs, w_w_hs, w_ar_hs, w_have_aw, w_have_w, w_done;

    function automatic logic [31:0] wb_addr(input logic [pADDR_WIDTH-1:0] a);
        return WB_BASE + {{(32-pADDR_WIDTH){1'b0}}, a};
    endfunction

    // Readies are held low while reset is asserted so nothing is accepted then.
    assign w_idle  = (r_state == IDLE);
    assign awready = rst_n && w_idle && !r_aw_got;
    assign wready  = rst_n && w_idle && !r_w_got;
    assign arready = rst_n && w_idle && !r_aw_got && !r_w_got && !awvalid && !wvalid;

    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;
    assign w_ar_hs   = arvalid && arready;
    assign w_have_aw = r_aw_got || w_aw_hs;
    assign w_have_w  = r_w_got || w_w_hs;
    assign w_done    = wbm_ack_i || (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_cnt    <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= '0;
            r_rvalid <= 1'b0;
            r_rresp  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_aw_got <= w_aw_got_nxt;
            r_w_got  <= w_w_got_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wstrb  <= w_wstrb_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cyc    <= w_cyc_nxt;
            r_we     <= w_we_nxt;
            r_sel    <= w_sel_nxt;
            r_adr    <= w_adr_nxt;
            r_dat    <= w_dat_nxt;
            r_bvalid <= w_bvalid_nxt;
            r_bresp  <= w_bresp_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rresp  <= w_rresp_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_aw_got_nxt = r_aw_got;
        w_w_got_nxt  = r_w_got;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_wstrb_nxt  = r_wstrb;
        w_cnt_nxt    = r_cnt;
        w_cyc_nxt    = r_cyc;
        w_we_nxt     = r_we;
        w_sel_nxt    = r_sel;
        w_adr_nxt    = r_adr;
        w_dat_nxt    = r_dat;
        w_bvalid_nxt = r_bvalid;
        w_bresp_nxt  = r_bresp;
        w_rvalid_nxt = r_rvalid;
        w_rresp_nxt  = r_rresp;
        w_rdata_nxt  = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_aw_got_nxt = 1'b1;
                    w_addr_nxt   = awaddr;
                end
                if (w_w_hs) begin
                    w_w_got_nxt = 1'b1;
                    w_wdata_nxt = wdata;
                    w_wstrb_nxt = wstrb;
                end
                // Same-cycle handshakes bypass the capture registers.
                if (w_have_aw && w_have_w) begin
                    w_state_nxt  = WB_WR;
                    w_aw_got_nxt = 1'b0;
                    w_w_got_nxt  = 1'b0;
                    w_cnt_nxt    = '0;
                    w_cyc_nxt    = 1'b1;
                    w_we_nxt     = 1'b1;
                    w_sel_nxt    = w_w_hs ? wstrb : r_wstrb;
                    w_dat_nxt    = w_w_hs ? wdata : r_wdata;
                    w_adr_nxt    = wb_addr(w_aw_hs ? awaddr : r_addr);
                end else if (w_ar_hs) begin
                    w_state_nxt = WB_RD;
                    w_cnt_nxt   = '0;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_sel_nxt   = 4'hF;
                    w_adr_nxt   = wb_addr(araddr);
                end
            end
            WB_WR, WB_RD: begin
                if (w_done) begin
                    w_cyc_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    w_cnt_nxt = '0;
                    if (r_state == WB_WR) begin
                        w_state_nxt  = B_RESP;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        w_state_nxt  = R_RESP;
                        w_rvalid_nxt = 1'b1;
                        w_rresp_nxt  = wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
                        w_rdata_nxt  = wbm_ack_i ? wbm_dat_i : '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            B_RESP: begin
                if (bready) begin
                    w_bvalid_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            R_RESP: begin
                if (rready) begin
                    w_rvalid_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bvalid    = r_bvalid;
    assign bresp     = r_bresp;
    assign rvalid    = r_rvalid;
    assign rresp     = r_rresp;
    assign rdata     = r_rdata;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign busy      = !w_idle;

endmodule

// File: tb/tb_axil_wb_master.sv
// tb/tb_axil_wb_master.sv - self-checking bench for axil_wb_master
// Expected Wishbone requests and AXI responses are queued at stimulus time and popped by monitors.
module tb_axil_wb_master;

    logic        clk, rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, busy;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

    typedef struct packed {
        logic        is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wbreq_t;

    resp_t  exp_q[$];
    wbreq_t wb_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_delay = 1;
    bit          no_ack = 1'b0;
    logic [31:0] rd_data = 32'h0;
    int          stb_run = 0;
    int          last_stb_len = 0;

    axil_wb_master #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .WB_BASE    (32'h3000_0000),
        .TIMEOUT    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rresp    (rresp),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void push_resp(input logic is_rd, input logic [1:0] resp, input logic [31:0] data);
        resp_t e;
        e.is_rd = is_rd;
        e.resp  = resp;
        e.data  = data;
        exp_q.push_back(e);
    endfunction

    function automatic void push_wb(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
        wbreq_t e;
        e.adr = adr;
        e.we  = we;
        e.sel = sel;
        e.dat = dat;
        wb_q.push_back(e);
    endfunction

    // Wishbone slave: checks each new request, acks after ack_delay strobe cycles.
    initial begin : wb_slave
        int     cnt;
        wbreq_t q;
        cnt = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            wbm_dat_i = rd_data;
            if (wbm_cyc_o && wbm_stb_o) begin
                cnt++;
                if (cnt == 1) begin
                    n_checks++;
                    if (wb_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL wb_unexpected_req adr=%h", wbm_adr_o);
                    end else begin
                        q = wb_q.pop_front();
                        if (wbm_adr_o !== q.adr || wbm_we_o !== q.we || wbm_sel_o !== q.sel ||
                            (q.we && wbm_dat_o !== q.dat)) begin
                            n_errors++;
                            $display("FAIL wb_req got adr=%h we=%b sel=%h dat=%h want adr=%h we=%b sel=%h dat=%h",
                                     wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_dat_o, q.adr, q.we, q.sel, q.dat);
                        end
                    end
                end
                wbm_ack_i = !no_ack && (cnt == ack_delay);
            end else begin
                cnt = 0;
                wbm_ack_i = 1'b0;
            end
        end
    end

    // Response monitor and strobe-length tracker, sampled on the falling edge.
    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stb_run = 0;
            end else begin
                if (wbm_stb_o) stb_run++;
                else if (stb_run != 0) begin
                    last_stb_len = stb_run;
                    stb_run = 0;
                end
                if (bvalid && bready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL b_unexpected bresp=%b", bresp);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_rd !== 1'b0 || bresp !== e.resp) begin
                            n_errors++;
                            $display("FAIL b_resp got write bresp=%b want is_rd=%b resp=%b", bresp, e.is_rd, e.resp);
                        end
                    end
                end
                if (rvalid && rready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL r_unexpected rresp=%b rdata=%h", rresp, rdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_rd !== 1'b1 || rresp !== e.resp || rdata !== e.data) begin
                            n_errors++;
                            $display("FAIL r_resp got read rresp=%b rdata=%h want is_rd=%b resp=%b data=%h",
                                     rresp, rdata, e.is_rd, e.resp, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output bit to);
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = 1'b0;
        w_done  = 1'b0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk);
            #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        to = !(aw_done && w_done);
    endtask

    task automatic axi_read(input logic [11:0] a, output bit to);
        bit done, hs;
        done = 1'b0;
        araddr = a;
        arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            hs = arvalid && arready;
            @(posedge clk);
            #1;
            if (hs) begin arvalid = 1'b0; done = 1'b1; end
        end
        arvalid = 1'b0;
        to = !done;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || rvalid !== 0 ||
            wbm_cyc_o !== 0 || wbm_stb_o !== 0 || wbm_we_o !== 0 || busy !== 0) begin
            n_errors++;
            $display("FAIL reset_ctrl got awr=%b wr=%b arr=%b bv=%b rv=%b cyc=%b stb=%b we=%b busy=%b want all 0",
                     awready, wready, arready, bvalid, rvalid, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy);
        end
        n_checks++;
        if (bresp !== 0 || rresp !== 0 || rdata !== 0 || wbm_sel_o !== 0 || wbm_adr_o !== 0 || wbm_dat_o !== 0) begin
            n_errors++;
            $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h sel=%h adr=%h dat=%h want all 0",
                     bresp, rresp, rdata, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (awready !== 1 || wready !== 1 || arready !== 1) begin
            n_errors++;
            $display("FAIL idle_readies got awr=%b wr=%b arr=%b want 1 1 1", awready, wready, arready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_aligned();
        bit to;
        ack_delay = 1; no_ack = 1'b0;
        push_wb(32'h3000_0010, 1'b1, 4'hF, 32'h0000_00AB);
        push_resp(1'b0, 2'b00, 32'h0);
        axi_write(12'h010, 32'h0000_00AB, 4'hF, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL wr_aligned_handshake timed out"); end
        n_checks++;
        if (wbm_cyc_o !== 1 || wbm_stb_o !== 1 || bvalid !== 0) begin
            n_errors++;
            $display("FAIL wr_aligned_cycle1 got cyc=%b stb=%b bvalid=%b want 1 1 0", wbm_cyc_o, wbm_stb_o, bvalid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bvalid !== 1 || bresp !== 2'b00 || wbm_cyc_o !== 0) begin
            n_errors++;
            $display("FAIL wr_aligned_cycle2 got bvalid=%b bresp=%b cyc=%b want 1 00 0", bvalid, bresp, wbm_cyc_o);
        end
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL wr_aligned_done timed out"); end
    endtask

    task automatic test_read_wait();
        bit to, got;
        int cyc_n;
        ack_delay = 3; no_ack = 1'b0; rd_data = 32'h1234_5678;
        push_wb(32'h3000_0084, 1'b0, 4'hF, 32'h0);
        push_resp(1'b1, 2'b00, 32'h1234_5678);
        axi_read(12'h084, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL rd_wait_handshake timed out"); end
        cyc_n = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc_n++;
            end
        end
        n_checks++;
        if (!got || cyc_n != 4 || rdata !== 32'h1234_5678 || rresp !== 2'b00) begin
            n_errors++;
            $display("FAIL rd_wait_rvalid got seen=%b cycle=%0d rdata=%h rresp=%b want 1 4 12345678 00",
                     got, cyc_n, rdata, rresp);
        end
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0 || last_stb_len != 3) begin
            n_errors++;
            $display("FAIL rd_wait_stb_len got %0d (timeout=%b) want 3", last_stb_len, to);
        end
    endtask

    task automatic test_w_before_aw_ar();
        bit to, seen;
        ack_delay = 2; no_ack = 1'b0; rd_data = 32'hCAFE_0003;
        push_wb(32'h3000_0020, 1'b1, 4'hF, 32'h0000_0005);
        push_wb(32'h3000_00C0, 1'b0, 4'hF, 32'h0);
        push_resp(1'b0, 2'b00, 32'h0);
        push_resp(1'b1, 2'b00, 32'hCAFE_0003);
        araddr = 12'h0C0; arvalid = 1'b1;
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wready !== 1 || arready !== 0) begin
            n_errors++;
            $display("FAIL w_first_ready got wready=%b arready=%b want 1 0", wready, arready);
        end
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (arready !== 0 || wready !== 0 || awready !== 1) begin
            n_errors++;
            $display("FAIL w_held_ready got arready=%b wready=%b awready=%b want 0 0 1", arready, wready, awready);
        end
        @(posedge clk);
        #1;
        awaddr = 12'h020; awvalid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (awready !== 1 || arready !== 0) begin
            n_errors++;
            $display("FAIL aw_late_ready got awready=%b arready=%b want 1 0", awready, arready);
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (arready) seen = 1'b1;
        end
        n_checks++;
        if (!seen || exp_q.size() != 1 || busy !== 0) begin
            n_errors++;
            $display("FAIL ar_after_write got seen=%b pending=%0d busy=%b want 1 1 0", seen, exp_q.size(), busy);
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL w_before_aw_done timed out"); end
    endtask

    task automatic test_b_backpressure();
        bit to, got;
        ack_delay = 1; no_ack = 1'b0;
        bready = 1'b0;
        push_wb(32'h3000_0030, 1'b1, 4'h3, 32'h0000_0077);
        push_resp(1'b0, 2'b00, 32'h0);
        axi_write(12'h030, 32'h0000_0077, 4'h3, to);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bvalid) got = 1'b1;
        end
        n_checks++;
        if (to !== 1'b0 || !got) begin
            n_errors++;
            $display("FAIL bp_bvalid got handshake_to=%b bvalid_seen=%b want 0 1", to, got);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bvalid !== 1 || bresp !== 2'b00 || awready !== 0 || wready !== 0) begin
                n_errors++;
                $display("FAIL bp_hold[%0d] got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                         i, bvalid, bresp, awready, wready);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bvalid !== 0 || awready !== 1) begin
            n_errors++;
            $display("FAIL bp_release got bvalid=%b awready=%b want 0 1", bvalid, awready);
        end
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL bp_done timed out"); end
    endtask

    task automatic test_timeout();
        bit to, got;
        int cyc_n;
        no_ack = 1'b1; rd_data = 32'hDEAD_BEEF;
        push_wb(32'h3000_0040, 1'b0, 4'hF, 32'h0);
        push_resp(1'b1, 2'b10, 32'h0);
        axi_read(12'h040, to);
        cyc_n = 1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (rvalid) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc_n++;
            end
        end
        n_checks++;
        if (to !== 1'b0 || !got || cyc_n != 9 || rresp !== 2'b10 || rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL timeout_resp got seen=%b cycle=%0d rresp=%b rdata=%h want 1 9 10 00000000",
                     got, cyc_n, rresp, rdata);
        end
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0 || last_stb_len != 8) begin
            n_errors++;
            $display("FAIL timeout_stb_len got %0d (timeout=%b) want 8", last_stb_len, to);
        end
        no_ack = 1'b0; ack_delay = 1; rd_data = 32'hA5A5_0048;
        push_wb(32'h3000_0048, 1'b0, 4'hF, 32'h0);
        push_resp(1'b1, 2'b00, 32'hA5A5_0048);
        axi_read(12'h048, to);
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL after_timeout_read timed out"); end
    endtask

    task automatic test_reset_mid();
        bit to;
        no_ack = 1'b1;
        push_wb(32'h3000_0050, 1'b1, 4'hF, 32'h0000_0099);
        axi_write(12'h050, 32'h0000_0099, 4'hF, to);
        @(negedge clk);
        n_checks++;
        if (to !== 1'b0 || busy !== 1 || wbm_cyc_o !== 1 || wbm_we_o !== 1) begin
            n_errors++;
            $display("FAIL rst_mid_pre got to=%b busy=%b cyc=%b we=%b want 0 1 1 1", to, busy, wbm_cyc_o, wbm_we_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wbm_cyc_o !== 0 || wbm_stb_o !== 0 || bvalid !== 0 || busy !== 0) begin
            n_errors++;
            $display("FAIL rst_mid_drop got cyc=%b stb=%b bvalid=%b busy=%b want 0 0 0 0",
                     wbm_cyc_o, wbm_stb_o, bvalid, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bvalid !== 0 || rvalid !== 0 || wbm_cyc_o !== 0) begin
                n_errors++;
                $display("FAIL rst_mid_quiet[%0d] got bvalid=%b rvalid=%b cyc=%b want 0 0 0", i, bvalid, rvalid, wbm_cyc_o);
            end
        end
        @(posedge clk);
        #1;
        no_ack = 1'b0; ack_delay = 2;
        push_wb(32'h3000_0000, 1'b1, 4'hF, 32'h0000_0003);
        push_resp(1'b0, 2'b00, 32'h0);
        axi_write(12'h000, 32'h0000_0003, 4'hF, to);
        wait_idle(to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL rst_mid_recover timed out"); end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        no_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 12'($urandom_range(0, 4095));
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            ack_delay = $urandom_range(1, 4);
            push_wb(32'h3000_0000 + {20'h0, a}, 1'b1, s, d);
            push_resp(1'b0, 2'b00, 32'h0);
            axi_write(a, d, s, to);
            wait_idle(to);
            n_checks++;
            if (to !== 1'b0) begin n_errors++; $display("FAIL b2b_write[%0d] timed out", i); end
            rd_data = $urandom;
            push_wb(32'h3000_0000 + {20'h0, a}, 1'b0, 4'hF, 32'h0);
            push_resp(1'b1, 2'b00, rd_data);
            axi_read(a, to);
            wait_idle(to);
            n_checks++;
            if (to !== 1'b0) begin n_errors++; $display("FAIL b2b_read[%0d] timed out", i); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 1'b0; awaddr = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; araddr = '0;
        bready = 1'b1; rready = 1'b1;
        test_reset();
        test_write_aligned();
        test_read_wait();
        test_w_before_aw_ar();
        test_b_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || wb_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover got resp=%0d wb=%0d pending want 0 0", exp_q.size(), wb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
